layer_serializer: RTL and testbench
===================================

Name: layer_serializer

Overview:
- Receiving end of a layer's parallel neuron outputs.
- Captures the NN per-neuron results, each flagged by its own valid bit, into a lane buffer.
- Once all NN lanes are captured, replays them one per cycle, neuron 0 first, as a serial x_valid/x_in-style stream for the next layer or the classifier.
- Downstream backpressure is supported; lane overruns are flagged.

Parameters:
- NN, 10, number of neurons/lanes in the upstream layer.
- dataWidth, 16, bit width of each neuron output.
- idxWidth, 4, width of the emitted neuron index; must satisfy 2^idxWidth >= NN.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets all state immediately.
- i_valid  input  NN  per-lane valid pulse from neuron outvalid.
- x_in  input  NN*dataWidth  lane k data at x_in[k*dataWidth +: dataWidth].
- o_ready  input  1  downstream accept; tie to 1 for a consumer without backpressure.
- err_clr  input  1  synchronous clear of the overrun flag.
- o_valid  output  1  serial data valid.
- o_data  output  dataWidth  serial data word.
- o_index  output  idxWidth  neuron index of o_data.
- o_last  output  1  high with the word for index NN-1.
- busy  output  1  high in SEND state.
- overrun  output  1  sticky lane-overrun flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=COLLECT, capture mask=0, send counter=0, lane buffer=0.
  - o_valid=0, o_data=0, o_index=0, o_last=0, busy=0, overrun=0.
  - Asserting reset mid-COLLECT or mid-SEND discards everything; no partial word is emitted after release.
- State COLLECT:
  - Each cycle, for every lane k with i_valid[k]=1: buffer[k]<=x_in lane k and mask[k]<=1.
  - Lanes may arrive in the same cycle or on different cycles, in any order.
  - Repeat valid on a lane with mask[k] already 1: data overwritten with the new value and overrun<=1.
  - Completion is evaluated on the next-state mask, i.e. old mask OR i_valid. If it is all ones, state<=SEND, counter<=0, mask<=0.
  - Consequence: o_valid first rises the cycle after the last lane is captured, giving 1-cycle capture-to-output latency.
- State SEND:
  - o_valid=1, o_data=buffer[counter], o_index=counter, o_last=(counter==NN-1), busy=1.
  - A word transfers on a cycle with o_valid & o_ready. On transfer, counter increments.
  - If o_ready=0, o_data/o_index/o_last hold stable and o_valid stays 1; o_valid never drops without a transfer.
  - Transfer with counter==NN-1: state<=COLLECT next cycle. o_valid=0 in that cycle, busy=0, counter<=0.
  - Any i_valid bit high while in SEND, including the final transfer cycle, is dropped (buffer and mask unchanged) and sets overrun<=1.
- Outputs are registered. In COLLECT, o_valid=0, o_last=0, and o_data/o_index hold their last values.
- overrun:
  - Sticky; cleared only by reset or by err_clr=1.
  - If err_clr and a new overrun event occur in the same cycle, the set wins (overrun=1).
- NN=1 degenerate case: a single word with o_last=1, then return to COLLECT.
- No arithmetic on data; words pass through bit-exact. The counter never exceeds NN-1.

Test Plan:
- All lanes simultaneous: after reset, one cycle of i_valid=10'h3FF with lane k data = 16'h0100+k, o_ready=1.
  - o_valid rises the next cycle.
  - Words 0x0100..0x0109 appear with o_index 0..9 on 10 consecutive cycles.
  - o_last=1 only on index 9; o_valid=0 on the following cycle; overrun=0.
- Staggered lanes: lanes pulse one per cycle in order 9 down to 0.
  - o_valid stays 0 until the cycle after lane 0 arrives.
  - Output order is still index 0..9 with the captured values.
- Backpressure: during SEND, hold o_ready=0 for 3 cycles at index 4.
  - o_valid=1 and o_data=buffer[4], o_index=4 stable for all 3 cycles; index 5 appears after o_ready returns to 1.
  - The full 10-word stream completes, with no duplicates and no drops.
- Overrun: pulse lane 2 twice in COLLECT (0x0AAA then 0x0BBB), then the remaining lanes.
  - Emitted index 2 = 0x0BBB; overrun=1.
  - A later i_valid during SEND leaves the stream unchanged and overrun stays 1.
  - err_clr=1 for one cycle -> overrun=0.
- Reset mid-SEND: drive rst=0 at index 6.
  - o_valid=0, busy=0, overrun=0 immediately (asynchronously).
  - After release, a fresh capture of data 0x0200+k streams 0x0200..0x0209 from index 0.
- Back-to-back frames: apply a second full i_valid frame on the cycle after the final transfer.
  - The second stream follows with exactly one idle cycle between o_last and the next index 0.

Source files
------------

// File: rtl/layer_serializer.sv
// Collects one result per neuron lane into a lane buffer, then replays the
// buffered words one per cycle (lane 0 first) as a valid/ready serial stream.
module layer_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    parameter int idxWidth  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   x_in,
    input  logic                      o_ready,
    input  logic                      err_clr,
    output logic                      o_valid,
    output logic [dataWidth-1:0]      o_data,
    output logic [idxWidth-1:0]       o_index,
    output logic                      o_last,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic [NN-1:0]                   mask_r;
    logic [NN-1:0]                   mask_nxt_s;
    logic [NN-1:0]                   mask_or_s;
    logic [NN-1:0][dataWidth-1:0]    buf_r;
    logic [NN-1:0][dataWidth-1:0]    buf_nxt_s;
    logic [idxWidth-1:0]             cnt_r;
    logic [idxWidth-1:0]             cnt_nxt_s;
    logic [idxWidth-1:0]             cnt_inc_s;
    logic                            ovr_set_s;
    logic                            o_valid_r;
    logic                            o_valid_nxt_s;
    logic [dataWidth-1:0]            o_data_r;
    logic [dataWidth-1:0]            o_data_nxt_s;
    logic [idxWidth-1:0]             o_index_r;
    logic [idxWidth-1:0]             o_index_nxt_s;
    logic                            o_last_r;
    logic                            o_last_nxt_s;
    logic                            busy_r;
    logic                            busy_nxt_s;
    logic                            overrun_r;

    // Mux one lane out of the buffer by index; out-of-range indices give zero.
    function automatic logic [dataWidth-1:0] lane_word(
        input logic [NN-1:0][dataWidth-1:0] lanes,
        input logic [idxWidth-1:0]          idx
    );
        logic [dataWidth-1:0] word;
        word = {dataWidth{1'b0}};
        for (int k = 0; k < NN; k++) begin
            word = (idx == idxWidth'(k)) ? lanes[k] : word;
        end
        return word;
    endfunction

    // Next-state, capture and next-output logic for the collect/send FSM.
    always_comb begin
        state_nxt_s   = state_r;
        mask_nxt_s    = mask_r;
        mask_or_s     = mask_r | i_valid;
        buf_nxt_s     = buf_r;
        cnt_nxt_s     = cnt_r;
        cnt_inc_s     = cnt_r + idxWidth'(1);
        ovr_set_s     = 1'b0;
        o_valid_nxt_s = o_valid_r;
        o_data_nxt_s  = o_data_r;
        o_index_nxt_s = o_index_r;
        o_last_nxt_s  = o_last_r;
        busy_nxt_s    = busy_r;

        case (state_r)
            COLLECT: begin
                for (int k = 0; k < NN; k++) begin
                    if (i_valid[k]) begin
                        buf_nxt_s[k] = x_in[k*dataWidth +: dataWidth];
                        ovr_set_s    = ovr_set_s | mask_r[k];
                    end else begin
                        buf_nxt_s[k] = buf_r[k];
                    end
                end
                // Completion looks at the post-capture mask so lane 0 can be
                // presented on the very next cycle.
                if (&mask_or_s) begin
                    state_nxt_s   = SEND;
                    mask_nxt_s    = {NN{1'b0}};
                    cnt_nxt_s     = {idxWidth{1'b0}};
                    o_valid_nxt_s = 1'b1;
                    o_data_nxt_s  = buf_nxt_s[0];
                    o_index_nxt_s = {idxWidth{1'b0}};
                    o_last_nxt_s  = (NN == 1);
                    busy_nxt_s    = 1'b1;
                end else begin
                    mask_nxt_s    = mask_or_s;
                    o_valid_nxt_s = 1'b0;
                    o_last_nxt_s  = 1'b0;
                    busy_nxt_s    = 1'b0;
                end
            end
            SEND: begin
                ovr_set_s = |i_valid;
                if (o_ready) begin
                    if (cnt_r == idxWidth'(NN - 1)) begin
                        state_nxt_s   = COLLECT;
                        cnt_nxt_s     = {idxWidth{1'b0}};
                        o_valid_nxt_s = 1'b0;
                        o_last_nxt_s  = 1'b0;
                        busy_nxt_s    = 1'b0;
                    end else begin
                        cnt_nxt_s     = cnt_inc_s;
                        o_valid_nxt_s = 1'b1;
                        o_data_nxt_s  = lane_word(buf_r, cnt_inc_s);
                        o_index_nxt_s = cnt_inc_s;
                        o_last_nxt_s  = (cnt_inc_s == idxWidth'(NN - 1));
                        busy_nxt_s    = 1'b1;
                    end
                end else begin
                    cnt_nxt_s     = cnt_r;
                    o_valid_nxt_s = o_valid_r;
                end
            end
            default: begin
                state_nxt_s   = COLLECT;
                mask_nxt_s    = {NN{1'b0}};
                cnt_nxt_s     = {idxWidth{1'b0}};
                o_valid_nxt_s = 1'b0;
                o_last_nxt_s  = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, lane buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= COLLECT;
            mask_r    <= {NN{1'b0}};
            buf_r     <= {(NN*dataWidth){1'b0}};
            cnt_r     <= {idxWidth{1'b0}};
            o_valid_r <= 1'b0;
            o_data_r  <= {dataWidth{1'b0}};
            o_index_r <= {idxWidth{1'b0}};
            o_last_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mask_r    <= mask_nxt_s;
            buf_r     <= buf_nxt_s;
            cnt_r     <= cnt_nxt_s;
            o_valid_r <= o_valid_nxt_s;
            o_data_r  <= o_data_nxt_s;
            o_index_r <= o_index_nxt_s;
            o_last_r  <= o_last_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Sticky overrun flag; a new event takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
        end else if (ovr_set_s) begin
            overrun_r <= 1'b1;
        end else if (err_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_index = o_index_r;
    assign o_last  = o_last_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed and random stimulus for layer_serializer, checked every cycle against
// a frame/queue level reference model of the serializer behaviour.
module tb_layer_serializer;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NN-1:0]      i_valid;
    logic [NN*DW-1:0]   x_in;
    logic               o_ready;
    logic               err_clr;
    logic               o_valid;
    logic [DW-1:0]      o_data;
    logic [IW-1:0]      o_index;
    logic               o_last;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } word_t;

    // Reference model: captured lanes, lanes seen, queue of words still to send.
    logic [DW-1:0] cap [NN];
    bit   [NN-1:0] got;
    word_t         pend [$];
    bit            m_ovr;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_idx;

    layer_serializer #(.NN(NN), .dataWidth(DW), .idxWidth(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .x_in    (x_in),
        .o_ready (o_ready),
        .err_clr (err_clr),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_index (o_index),
        .o_last  (o_last),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        bit sending;
        sending = (pend.size() > 0);
        chk({ctx, ":o_valid"}, 32'(o_valid), 32'(sending));
        chk({ctx, ":busy"},    32'(busy),    32'(sending));
        chk({ctx, ":overrun"}, 32'(overrun), 32'(m_ovr));
        chk({ctx, ":o_last"},  32'(o_last),  32'(sending && (m_idx == IW'(NN - 1))));
        chk({ctx, ":o_data"},  32'(o_data),  32'(m_data));
        chk({ctx, ":o_index"}, 32'(o_index), 32'(m_idx));
    endtask

    task automatic model_clear();
        pend.delete();
        got    = '0;
        m_ovr  = 1'b0;
        m_data = '0;
        m_idx  = '0;
        for (int k = 0; k < NN; k++) cap[k] = '0;
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic drive(input logic [NN-1:0] iv, input logic rdy, input logic clr, input string ctx);
        bit ovr_set;
        ovr_set = 1'b0;
        i_valid = iv;
        o_ready = rdy;
        err_clr = clr;
        if (pend.size() > 0) begin
            if (iv != '0) ovr_set = 1'b1;
            if (rdy) void'(pend.pop_front());
        end else begin
            for (int k = 0; k < NN; k++) begin
                if (iv[k]) begin
                    if (got[k]) ovr_set = 1'b1;
                    cap[k] = x_in[k*DW +: DW];
                    got[k] = 1'b1;
                end
            end
            if (&got) begin
                for (int k = 0; k < NN; k++) pend.push_back('{cap[k], IW'(k)});
                got = '0;
            end
        end
        m_ovr = ovr_set | (m_ovr & !clr);
        if (pend.size() > 0) begin
            m_data = pend[0].d;
            m_idx  = pend[0].i;
        end
        @(posedge clk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic drain(input string ctx);
        for (int n = 0; n < 40 && pend.size() > 0; n++) drive('0, 1'b1, 1'b0, ctx);
        drive('0, 1'b1, 1'b0, ctx);
    endtask

    task automatic set_lanes(input logic [DW-1:0] base);
        for (int k = 0; k < NN; k++) x_in[k*DW +: DW] = base + DW'(k);
    endtask

    // Asynchronous reset applied between clock edges and checked before any edge.
    task automatic do_reset(input string ctx);
        rst     = 1'b0;
        i_valid = '0;
        o_ready = 1'b1;
        err_clr = 1'b0;
        #2;
        model_clear();
        check_outputs(ctx);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = '0;
        x_in    = '0;
        o_ready = 1'b1;
        err_clr = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset("reset");

        // All lanes in one cycle.
        set_lanes(16'h0100);
        drive('1, 1'b1, 1'b0, "simul");
        chk("simul:first_word", 32'(o_data), 32'h0000_0100);
        drain("simul");

        // Lanes arrive one per cycle, 9 down to 0.
        set_lanes(16'h0300);
        for (int k = NN - 1; k >= 0; k--) drive(NN'(1) << k, 1'b1, 1'b0, "stagger");
        drain("stagger");

        // Backpressure held at index 4 for three cycles.
        set_lanes(16'h0400);
        drive('1, 1'b1, 1'b0, "bp");
        for (int n = 0; n < 4; n++) drive('0, 1'b1, 1'b0, "bp");
        for (int n = 0; n < 3; n++) drive('0, 1'b0, 1'b0, "bp_hold");
        chk("bp:held_index", 32'(o_index), 32'd4);
        drain("bp");

        // Repeat capture on lane 2, drops during SEND, then clear.
        x_in[2*DW +: DW] = 16'h0AAA;
        drive(NN'(1) << 2, 1'b1, 1'b0, "ovr");
        x_in[2*DW +: DW] = 16'h0BBB;
        drive(NN'(1) << 2, 1'b1, 1'b0, "ovr");
        for (int k = 0; k < NN; k++) if (k != 2) x_in[k*DW +: DW] = 16'h0500 + DW'(k);
        drive(~(NN'(1) << 2), 1'b1, 1'b0, "ovr");
        for (int n = 0; n < 2; n++) drive('0, 1'b1, 1'b0, "ovr");
        chk("ovr:lane2_word", 32'(o_data), 32'h0000_0BBB);
        x_in = '1;
        drive(NN'(1) << 5, 1'b1, 1'b0, "ovr_drop");
        for (int n = 0; n < 6; n++) drive('0, 1'b1, 1'b0, "ovr");
        drive('1, 1'b1, 1'b0, "ovr_final_drop");
        drive('0, 1'b1, 1'b1, "ovr_clr");
        chk("ovr:cleared", 32'(overrun), 32'd0);

        // Reset in the middle of a stream.
        set_lanes(16'h0600);
        drive('1, 1'b1, 1'b0, "midrst");
        drive(NN'(1), 1'b1, 1'b0, "midrst");
        for (int n = 0; n < 20 && !(pend.size() > 0 && m_idx == IW'(6)); n++) drive('0, 1'b1, 1'b0, "midrst");
        do_reset("midrst_reset");
        set_lanes(16'h0200);
        drive('1, 1'b1, 1'b0, "after_rst");
        chk("after_rst:first_word", 32'(o_data), 32'h0000_0200);
        drain("after_rst");

        // Back-to-back frames: second frame on the cycle after the final transfer.
        set_lanes(16'h0700);
        drive('1, 1'b1, 1'b0, "b2b");
        for (int n = 0; n < NN; n++) drive('0, 1'b1, 1'b0, "b2b");
        set_lanes(16'h0800);
        drive('1, 1'b1, 1'b0, "b2b_second");
        drain("b2b");

        // Random traffic with random backpressure and clears.
        for (int n = 0; n < 600; n++) begin
            logic [NN-1:0] iv;
            for (int k = 0; k < NN; k++) begin
                x_in[k*DW +: DW] = DW'($urandom);
                iv[k] = ($urandom_range(0, 3) == 0);
            end
            drive(iv, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");
        end
        drain("rand_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
